// File: rtl/button_conditioner.sv
// Per-channel button debouncer with registered press/release pulses.
// Define BUTTON_AUTOREPEAT_EN to re-issue press while a button stays held.
module button_conditioner #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_BITS      = 11,
    parameter int REPEAT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_press
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        CONFIRM_HIGH,
        HELD_HIGH,
        CONFIRM_LOW
    } state_e;

    localparam logic [CNT_BITS-1:0] STABLE_LAST = CNT_BITS'(STABLE_CYCLES - 1);

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [CNT_BITS-1:0] cnt_q   [CHANNELS];
    logic [CNT_BITS-1:0] cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic                any_press_q, any_press_d;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_BITS-1:0] REPEAT_LAST = CNT_BITS'(REPEAT_CYCLES - 1);
    logic [CNT_BITS-1:0] rcnt_q [CHANNELS];
    logic [CNT_BITS-1:0] rcnt_d [CHANNELS];
`else
    localparam int unused_repeat_cycles = REPEAT_CYCLES;
`endif

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            // Cleared whenever the channel is not remaining in HELD_HIGH
            rcnt_d[i]    = '0;
`endif
            unique case (state_q[i])
                IDLE_LOW: begin
                    if (raw[i]) begin
                        state_d[i] = CONFIRM_HIGH;
                        cnt_d[i]   = '0;
                    end
                end
                CONFIRM_HIGH: begin
                    if (!raw[i]) begin
                        state_d[i] = IDLE_LOW;
                    end else if (cnt_q[i] == STABLE_LAST) begin
                        state_d[i] = HELD_HIGH;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                HELD_HIGH: begin
                    if (!raw[i]) begin
                        state_d[i] = CONFIRM_LOW;
                        cnt_d[i]   = '0;
                    end
`ifdef BUTTON_AUTOREPEAT_EN
                    else if (rcnt_q[i] == REPEAT_LAST) begin
                        press_d[i] = 1'b1;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + 1'b1;
                    end
`endif
                end
                CONFIRM_LOW: begin
                    if (raw[i]) begin
                        state_d[i] = HELD_HIGH;
                    end else if (cnt_q[i] == STABLE_LAST) begin
                        state_d[i]   = IDLE_LOW;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = IDLE_LOW;
            endcase
        end
        any_press_d = |press_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE_LOW;
                cnt_q[i]   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
                rcnt_q[i]  <= '0;
`endif
            end
            press_q     <= '0;
            release_q   <= '0;
            any_press_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef BUTTON_AUTOREPEAT_EN
                rcnt_q[i]  <= rcnt_d[i];
`endif
            end
            press_q     <= press_d;
            release_q   <= release_d;
            any_press_q <= any_press_d;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            level[i] = (state_q[i] == HELD_HIGH) || (state_q[i] == CONFIRM_LOW);
        end
    end

    assign press         = press_q;
    assign release_pulse = release_q;
    assign any_press     = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with STABLE_CYCLES=4, REPEAT_CYCLES=10.
// Expected pulses are queued with their cycle; a negedge monitor pops and compares.
module tb_button_conditioner;

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] l;
        logic       a;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic       any_press;

    int   cyc = 0;
    int   base = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_conditioner #(
        .CHANNELS(4),
        .STABLE_CYCLES(4),
        .CNT_BITS(11),
        .REPEAT_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw(raw),
        .level(level),
        .press(press),
        .release_pulse(release_pulse),
        .any_press(any_press)
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endfunction

    function automatic void push(int off, logic [3:0] p, logic [3:0] r, logic [3:0] l);
        exp_t e;
        e.cyc = base + off;
        e.p   = p;
        e.r   = r;
        e.l   = l;
        e.a   = |p;
        q.push_back(e);
    endfunction

    // Called while sitting at a negedge: next driven value is sampled at edge cyc+1
    task automatic mark();
        base = cyc + 1;
    endtask

    task automatic apply(logic [3:0] v, int n);
        repeat (n) begin
            raw = v;
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if ((|press) || (|release_pulse) || any_press) begin
            if (q.size() == 0) begin
                check("unexpected_pulse",
                      {19'd0, cyc, press, release_pulse, level, any_press}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse",
                      {19'd0, cyc, press, release_pulse, level, any_press},
                      {19'd0, e.cyc, e.p, e.r, e.l, e.a});
            end
        end
    end

    initial begin
        logic [15:0] pat;
        reset = 1'b1;
        raw   = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_state", {51'd0, level, press, release_pulse, any_press}, 64'd0);
        reset = 1'b0;
        apply(4'b0000, 2);

        // ch0 clean press and release
        mark();
        push(4, 4'b0001, 4'b0000, 4'b0001);
        push(12, 4'b0000, 4'b0001, 4'b0000);
        apply(4'b0001, 8);
        apply(4'b0000, 8);

        // ch1 bounce on both press and release
        mark();
        push(7, 4'b0010, 4'b0000, 4'b0010);
        push(15, 4'b0000, 4'b0010, 4'b0000);
        pat = 16'h04FB;
        for (int i = 0; i < 16; i++) apply({2'b00, pat[i], 1'b0}, 1);
        apply(4'b0000, 3);

        // ch2 reset while held, then re-qualify
        mark();
        push(4, 4'b0100, 4'b0000, 4'b0100);
        apply(4'b0100, 7);
        reset = 1'b1;
        @(negedge clk);
        check("reset_drop_level", {60'd0, level}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mark();
        push(4, 4'b0100, 4'b0000, 4'b0100);
        push(11, 4'b0000, 4'b0100, 4'b0000);
        apply(4'b0100, 7);
        apply(4'b0000, 8);

        // all channels rise together
        mark();
        push(4, 4'b1111, 4'b0000, 4'b1111);
        push(9, 4'b0000, 4'b1111, 4'b0000);
        apply(4'b1111, 5);
        apply(4'b0000, 8);

        // ch3 long hold
        mark();
        push(4, 4'b1000, 4'b0000, 4'b1000);
`ifdef BUTTON_AUTOREPEAT_EN
        for (int r = 1; r <= 4; r++) push(4 + 10 * r, 4'b1000, 4'b0000, 4'b1000);
`endif
        push(49, 4'b0000, 4'b1000, 4'b0000);
        apply(4'b1000, 45);
        apply(4'b0000, 10);

        check("pending_expectations", 64'(q.size()), 64'd0);
        check("final_level", {60'd0, level}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
